// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and helpers for the APB completer memory
// Purpose: FSM state encoding, protection-requirement helpers and the word
// alignment mask used by apb_completer_mem.
// Ports: none (package).
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } apb_cmp_state_e;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // Address bits 6:4 select the privilege/security/instruction level a
    // transfer must carry to reach that region of the memory.
    function automatic logic [2:0] req_pprot(input logic [6:0] addr);
        return {addr[6], addr[5], addr[4]};
    endfunction

    function automatic logic pprot_ok(input logic [6:0] addr, input logic [2:0] prot);
        return (req_pprot(addr) & ~prot) == 3'b000;
    endfunction

endpackage

// File: rtl/apb_strb_mem.sv
// rtl/apb_strb_mem.sv - DEPTH-word register memory with byte-masked write
// Purpose: storage behind the APB completer; cleared on reset.
// Ports:
//   pclk, reset          clock, synchronous active-high reset (clears all words)
//   rd_idx / rd_data     asynchronous read port
//   wr_en, wr_idx,
//   wr_data, wr_strb     synchronous write port, one enable bit per byte lane
module apb_strb_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 64,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[rd_idx];

    always_ff @(posedge pclk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/apb_completer_mem.sv
// rtl/apb_completer_mem.sv - APB4 completer in front of a byte-strobed register memory
// Purpose: accepts APB reads/writes, inserts WAIT_STATES access cycles, and
// flags PSLVERR on misalignment, out-of-range, protection failure or abort.
// Optional: define APB_PROT_CHECK_EN to enable the pprot protection check.
// Ports:
//   pclk, reset                       clock, synchronous active-high reset
//   psel, penable, pwrite, paddr,
//   pwdata, pstrb, pprot              APB requester inputs
//   prdata, pready, pslverr           registered APB response outputs
module apb_completer_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_WIDTH-1:0] pstrb,
    input  logic [2:0]            pprot,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int                    IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BYTE_LIMIT = ADDR_WIDTH'(DEPTH * 4);
    localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);

    apb_cmp_state_e        state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic                  setup;
    logic                  load_setup;
    logic                  prot_err;
    logic                  xfer_err;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

`ifdef APB_PROT_CHECK_EN
    logic [2:0] prot_q, prot_d;
    assign prot_err = !pprot_ok(addr_q[6:0], prot_q);
`else
    logic unused_pprot;
    assign unused_pprot = ^pprot;
    assign prot_err     = 1'b0;
`endif

    assign setup    = psel && !penable;
    assign xfer_err = ((addr_q[1:0] & WORD_ALIGN_MASK) != 2'b00)
                    || (addr_q >= BYTE_LIMIT)
                    || prot_err;

    apb_strb_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .pclk    (pclk),
        .reset   (reset),
        .rd_idx  (addr_q[2 +: IDX_W]),
        .rd_data (mem_rdata),
        .wr_en   (mem_we),
        .wr_idx  (addr_q[2 +: IDX_W]),
        .wr_data (wdata_q),
        .wr_strb (strb_q)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
`ifdef APB_PROT_CHECK_EN
        prot_d     = prot_q;
`endif
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        prdata_d   = '0;
        mem_we     = 1'b0;
        load_setup = 1'b0;

        case (state_q)
            IDLE: begin
                if (setup) begin
                    load_setup = 1'b1;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel || !penable) begin
                    // Requester dropped out of the access phase: error, no write.
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    pready_d  = 1'b1;
                    pslverr_d = xfer_err;
                    mem_we    = write_q && !xfer_err;
                    prdata_d  = (write_q || xfer_err) ? '0 : mem_rdata;
                    state_d   = RESP;
                end
            end
            RESP: begin
                // A setup phase overlapping the response cycle starts the next transfer.
                if (setup) begin
                    load_setup = 1'b1;
                    state_d    = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_setup) begin
            addr_d  = paddr;
            write_d = pwrite;
            wdata_d = pwdata;
            strb_d  = pstrb;
            cnt_d   = WAIT_INIT;
`ifdef APB_PROT_CHECK_EN
            prot_d  = pprot;
`endif
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
`ifdef APB_PROT_CHECK_EN
            prot_q    <= '0;
`endif
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
`ifdef APB_PROT_CHECK_EN
            prot_q    <= prot_d;
`endif
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_completer_mem.sv
// tb/tb_apb_completer_mem.sv - self-checking bench for apb_completer_mem
module tb_apb_completer_mem;

    localparam int WS    = 1;
    localparam int DEPTH = 64;
`ifdef APB_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        reset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    always #5 pclk = ~pclk;

    apb_completer_mem #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STRB_WIDTH  (4),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .pclk    (pclk),
        .reset   (reset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .pprot   (pprot),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl [DEPTH];
    bit          checking  = 1'b0;
    bit          exp_resp  = 1'b0;
    logic        exp_err   = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic        got_err;
    logic [31:0] got_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the DUT response against the model's expectation.
    always @(negedge pclk) begin
        if (checking) begin
            chk("pready", {31'b0, pready}, {31'b0, exp_resp});
            if (exp_resp && pready) begin
                chk("pslverr", {31'b0, pslverr}, {31'b0, exp_err});
                chk("prdata", prdata, exp_rdata);
                got_err   = pslverr;
                got_rdata = prdata;
            end
        end
    end

    // One transfer; entered and left at posedge+1. Leaves the bench in the
    // response cycle with psel low, so a following xfer call is back-to-back.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p, input bit abort);
        logic        err;
        logic [31:0] rdat;
        logic [5:0]  idx;
        idx  = a[7:2];
        err  = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4))
             || (PROT_EN && ((({a[6], a[5], a[4]}) & ~p) != 3'b000)) || abort;
        rdat = (wr || err) ? 32'h0 : mdl[idx];
        got_err   = 1'bx;
        got_rdata = 'x;
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = a; pwdata = d; pstrb = s; pprot = p;
        @(posedge pclk); #1;
        exp_resp = 1'b0;
        penable  = 1'b1;
        @(posedge pclk); #1;
        // Latched values must win over anything driven later in the transfer.
        paddr  = $urandom;
        pwdata = $urandom;
        pwrite = $urandom_range(0, 1);
        if (abort) begin
            psel = 1'b0; penable = 1'b0;
            @(posedge pclk); #1;
        end else begin
            repeat (WS) begin
                @(posedge pclk); #1;
            end
        end
        exp_resp  = 1'b1;
        exp_err   = err;
        exp_rdata = rdat;
        psel = 1'b0; penable = 1'b0;
        if (wr && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge pclk); #1;
        exp_resp = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] p,
                      input logic e_err, input logic [31:0] e_data);
        xfer(1'b0, a, 32'h0, 4'h0, p, 1'b0);
        idle_cycle();
        chk("lit_err", {31'b0, got_err}, {31'b0, e_err});
        chk("lit_rdata", got_rdata, e_data);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit abort, input logic e_err);
        xfer(1'b1, a, d, s, 3'b000, abort);
        idle_cycle();
        chk("lit_werr", {31'b0, got_err}, {31'b0, e_err});
        chk("lit_wdata", got_rdata, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_pready", {31'b0, pready}, 32'h0);
        chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        @(posedge pclk); #1;
        reset    = 1'b0;
        checking = 1'b1;

        rd(32'h04, 3'b000, 1'b0, 32'h0);
        wr(32'h04, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
        rd(32'h04, 3'b000, 1'b0, 32'hFFFF_FFFF);
        wr(32'h84, 32'hFFFF_FFFF, 4'h1, 1'b0, 1'b0);
        rd(32'h84, 3'b000, 1'b0, 32'h0000_00FF);

        rd(32'h74, 3'b111, 1'b0, 32'h0);
        rd(32'h74, 3'b110, PROT_EN, 32'h0);
        rd(32'h74, 3'b101, PROT_EN, 32'h0);
        rd(32'h74, 3'b011, PROT_EN, 32'h0);

        rd(32'h03, 3'b000, 1'b1, 32'h0);
        rd(32'h100, 3'b000, 1'b1, 32'h0);
        wr(32'h03, 32'hAAAA_AAAA, 4'hF, 1'b0, 1'b1);
        wr(32'h100, 32'h5555_5555, 4'hF, 1'b0, 1'b1);
        rd(32'h00, 3'b000, 1'b0, 32'h0);
        rd(32'h04, 3'b000, 1'b0, 32'hFFFF_FFFF);

        wr(32'h04, 32'h1234_5678, 4'hF, 1'b1, 1'b1);
        rd(32'h04, 3'b000, 1'b0, 32'hFFFF_FFFF);

        wr(32'h04, 32'h0000_0000, 4'h0, 1'b0, 1'b0);
        rd(32'h04, 3'b000, 1'b0, 32'hFFFF_FFFF);

        xfer(1'b1, 32'h08, 32'hCAFE_F00D, 4'hF, 3'b000, 1'b0);
        xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 1'b0);
        idle_cycle();
        chk("b2b_rdata", got_rdata, 32'hCAFE_F00D);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                1:       a = 32'h100 + {$urandom_range(0, 255), 2'b00};
                default: a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            endcase
            xfer($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        checking = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
